// File: rtl/pwd_set_multi.sv
// Password entry: captures a DIGITS-long code one digit per strobe, with backspace, confirm and optional timeout.
// Latency 1 cycle, all outputs registered; no backpressure, every strobe is one event. Optional double entry: PWSET_CONFIRM_TWICE_EN.
module pwd_set_multi #(
    parameter int DIGITS      = 3,
    parameter int DIGIT_W     = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set,
    input  logic                          confirm,
    input  logic                          back,
    input  logic                          keyboard_en,
    input  logic [DIGIT_W-1:0]            keyboard_num,
    output logic [DIGITS-1:0]             seat,
    output logic [DIGITS*DIGIT_W-1:0]     setnum,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          setend,
    output logic                          set_led,
    output logic                          set_err
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int NW = DIGITS * DIGIT_W;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENTRY  = 2'd1;
`ifdef PWSET_CONFIRM_TWICE_EN
    localparam logic [1:0] VERIFY = 2'd2;
`endif
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state, state_n;
    logic [NW-1:0]     setnum_n;
    logic [DIGITS-1:0] seat_n;
    logic [CW-1:0]     count_n;
    logic              set_err_n;
    logic [TW-1:0]     to_cnt, to_cnt_n;
    logic [NW-1:0]     work, work_n;
    logic [DIGITS-1:0] wseat_n;
    logic              active, accepted;
`ifdef PWSET_CONFIRM_TWICE_EN
    logic [NW-1:0]     sh_num, sh_num_n;
`endif

    always_comb begin
        state_n   = state;
        setnum_n  = setnum;
        seat_n    = seat;
        count_n   = count;
        set_err_n = 1'b0;
        to_cnt_n  = to_cnt;
        accepted  = 1'b0;
`ifdef PWSET_CONFIRM_TWICE_EN
        sh_num_n  = sh_num;
        // In VERIFY digits and backspace land in the shadow buffer; setnum stays frozen.
        work      = (state == VERIFY) ? sh_num : setnum;
        active    = (state == ENTRY) || (state == VERIFY);
`else
        work      = setnum;
        active    = (state == ENTRY);
`endif
        work_n    = work;
        wseat_n   = seat;

        if (set) begin
            state_n  = ENTRY;
            setnum_n = '1;
            seat_n   = '1;
            count_n  = '0;
            to_cnt_n = '0;
`ifdef PWSET_CONFIRM_TWICE_EN
            sh_num_n = '1;
`endif
        end else if (active) begin
            if (back) begin
                if (count != '0) begin
                    accepted = 1'b1;
                    count_n  = count - CW'(1);
                    for (int k = 0; k < DIGITS; k++) begin
                        if (CW'(k) == count_n) begin
                            work_n[(DIGITS-k)*DIGIT_W-1 -: DIGIT_W] = '1;
                            wseat_n[DIGITS-1-k] = 1'b1;
                        end
                    end
                end
            end else if (keyboard_en) begin
                if (count != CNT_FULL) begin
                    accepted = 1'b1;
                    count_n  = count + CW'(1);
                    for (int k = 0; k < DIGITS; k++) begin
                        if (CW'(k) == count) begin
                            work_n[(DIGITS-k)*DIGIT_W-1 -: DIGIT_W] = keyboard_num;
                            wseat_n[DIGITS-1-k] = 1'b0;
                        end
                    end
                end
            end

`ifdef PWSET_CONFIRM_TWICE_EN
            if (state == VERIFY) begin
                sh_num_n = work_n;
            end else begin
                setnum_n = work_n;
                seat_n   = wseat_n;
            end
`else
            setnum_n = work_n;
            seat_n   = wseat_n;
`endif

            if (!back && !keyboard_en && confirm) begin
                accepted = 1'b1;
                if (count != CNT_FULL) begin
                    set_err_n = 1'b1;
`ifdef PWSET_CONFIRM_TWICE_EN
                end else if (state == ENTRY) begin
                    state_n  = VERIFY;
                    count_n  = '0;
                    sh_num_n = '1;
                end else if (sh_num == setnum) begin
                    state_n  = DONE;
                end else begin
                    state_n   = ENTRY;
                    setnum_n  = '1;
                    seat_n    = '1;
                    count_n   = '0;
                    sh_num_n  = '1;
                    set_err_n = 1'b1;
                end
`else
                end else begin
                    state_n = DONE;
                end
`endif
            end

            // Inactivity timeout abandons the entry entirely.
            if (TIMEOUT_CYC > 0) begin
                if (accepted) begin
                    to_cnt_n = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n   = IDLE;
                    setnum_n  = '1;
                    seat_n    = '1;
                    count_n   = '0;
                    set_err_n = 1'b1;
                    to_cnt_n  = '0;
`ifdef PWSET_CONFIRM_TWICE_EN
                    sh_num_n  = '1;
`endif
                end else begin
                    to_cnt_n = to_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            setnum  <= '1;
            seat    <= '1;
            count   <= '0;
            setend  <= 1'b0;
            set_led <= 1'b0;
            set_err <= 1'b0;
            to_cnt  <= '0;
`ifdef PWSET_CONFIRM_TWICE_EN
            sh_num  <= '1;
`endif
        end else begin
            state   <= state_n;
            setnum  <= setnum_n;
            seat    <= seat_n;
            count   <= count_n;
            setend  <= (state_n == DONE);
            set_led <= (state_n == DONE);
            set_err <= set_err_n;
            to_cnt  <= to_cnt_n;
`ifdef PWSET_CONFIRM_TWICE_EN
            sh_num  <= sh_num_n;
`endif
        end
    end
endmodule

// File: tb/tb_pwd_set_multi.sv
// Directed bench for pwd_set_multi (DIGITS=3, DIGIT_W=4, TIMEOUT_CYC=16).
module tb_pwd_set_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0;
    logic        confirm = 1'b0;
    logic        back = 1'b0;
    logic        keyboard_en = 1'b0;
    logic [3:0]  keyboard_num = 4'h0;
    logic [2:0]  seat;
    logic [11:0] setnum;
    logic [1:0]  count;
    logic        setend;
    logic        set_led;
    logic        set_err;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwd_set_multi #(.DIGITS(3), .DIGIT_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .set(set), .confirm(confirm), .back(back),
        .keyboard_en(keyboard_en), .keyboard_num(keyboard_num),
        .seat(seat), .setnum(setnum), .count(count),
        .setend(setend), .set_led(set_led), .set_err(set_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_buf(input string tag, input logic [11:0] en, input logic [2:0] es, input logic [1:0] ec);
        chk({tag, ".setnum"}, 32'(setnum), 32'(en));
        chk({tag, ".seat"}, 32'(seat), 32'(es));
        chk({tag, ".count"}, 32'(count), 32'(ec));
    endtask

    task automatic cyc(input logic s, input logic c, input logic b, input logic k, input logic [3:0] n);
        set = s; confirm = c; back = b; keyboard_en = k; keyboard_num = n;
        @(posedge clk); #1;
        set = 1'b0; confirm = 1'b0; back = 1'b0; keyboard_en = 1'b0;
    endtask

    task automatic key(input logic [3:0] n);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, n);
    endtask

    initial begin
        // reset state
        #12;
        chk_buf("reset", 12'hFFF, 3'b111, 2'd0);
        chk("reset.setend", 32'(setend), 32'd0);
        chk("reset.set_led", 32'(set_led), 32'd0);
        chk("reset.set_err", 32'(set_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // digits before set are ignored in IDLE
        key(4'h7);
        chk_buf("idle_key", 12'hFFF, 3'b111, 2'd0);

        // basic entry 1,2,3 then confirm
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk_buf("t1.set", 12'hFFF, 3'b111, 2'd0);
        key(4'h1);
        chk_buf("t1.d1", 12'h1FF, 3'b011, 2'd1);
        key(4'h2);
        chk_buf("t1.d2", 12'h12F, 3'b001, 2'd2);
        key(4'h3);
        chk_buf("t1.d3", 12'h123, 3'b000, 2'd3);
        chk("t1.setend_pre", 32'(setend), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("t1.setend", 32'(setend), 32'd1);
        chk("t1.set_led", 32'(set_led), 32'd1);
        chk("t1.set_err", 32'(set_err), 32'd0);
        key(4'h9);
        chk_buf("t1.done_hold", 12'h123, 3'b000, 2'd3);
        chk("t1.setend_hold", 32'(setend), 32'd1);

        // backspace editing
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("t2.setend_clr", 32'(setend), 32'd0);
        key(4'h5);
        key(4'h6);
        chk_buf("t2.d56", 12'h56F, 3'b001, 2'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        chk_buf("t2.back", 12'h5FF, 3'b011, 2'd1);
        key(4'h7);
        key(4'h8);
        chk_buf("t2.d78", 12'h578, 3'b000, 2'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("t2.setend", 32'(setend), 32'd1);
        chk("t2.set_err", 32'(set_err), 32'd0);
        chk("t2.setnum", 32'(setnum), 32'h578);

        // short confirm, full buffer, back at zero, back beats keyboard
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        chk_buf("t3.back0", 12'hFFF, 3'b111, 2'd0);
        key(4'h4);
        key(4'h9);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("t3.err", 32'(set_err), 32'd1);
        chk("t3.setend", 32'(setend), 32'd0);
        chk_buf("t3.short", 12'h49F, 3'b001, 2'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("t3.err_one", 32'(set_err), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
        chk_buf("t3.prio", 12'h4FF, 3'b011, 2'd1);
        key(4'h9);
        key(4'h2);
        chk_buf("t3.d2", 12'h492, 3'b000, 2'd3);
        key(4'h5);
        chk_buf("t3.full", 12'h492, 3'b000, 2'd3);
        chk("t3.full_err", 32'(set_err), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("t3.setend", 32'(setend), 32'd1);
        chk("t3.setnum", 32'(setnum), 32'h492);

        // inactivity timeout
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h3);
        chk_buf("t4.d3", 12'h3FF, 3'b011, 2'd1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("t4.pre_err", 32'(set_err), 32'd0);
        chk_buf("t4.pre", 12'h3FF, 3'b011, 2'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("t4.err", 32'(set_err), 32'd1);
        chk_buf("t4.to", 12'hFFF, 3'b111, 2'd0);
        key(4'h4);
        chk("t4.err_one", 32'(set_err), 32'd0);
        chk_buf("t4.ignored", 12'hFFF, 3'b111, 2'd0);

        // asynchronous reset mid-entry
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h6);
        chk_buf("t5.d6", 12'h6FF, 3'b011, 2'd1);
        #1 rst = 1'b1;
        #1;
        chk_buf("t5.arst", 12'hFFF, 3'b111, 2'd0);
        chk("t5.setend", 32'(setend), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        key(4'h3);
        chk_buf("t5.after", 12'hFFF, 3'b111, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
